access_code_correlator: RTL and testbench

- Receive-side counterpart of the header bit transmitter.
- Runs a sliding correlation of the incoming rxbit stream against the selected 64-bit sync word, inside a slot-timed search window.
- On detection, tracks the trailer and issues rx_trailer_st_p, timed so that the header decoder starts on the correct microsecond tick.
- Also reports the sync error count, trailer integrity and search timeout to the link controller.

---
 rtl/access_code_pkg.sv | 30 +++
 rtl/ac_popcount64.sv | 28 ++
 rtl/access_code_correlator.sv | 169 ++++++++++++++++
 tb/tb_access_code_correlator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/access_code_pkg.sv
// -----------------------------------------------------------------------------
// access_code_pkg
// Shared definitions for the access code correlator:
//   - corr_state_e : correlator FSM state encoding (also driven out on corr_state)
//   - SW_LEN       : sync word length in bits
//   - TRL_PAT_*    : expected 4-bit trailer, first received bit in bit [3]
//   - trl_pattern  : selects the trailer pattern from the sync word LSB
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package access_code_pkg;

  localparam int SW_LEN = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_TRAILER = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_EXPIRED = 3'd4
  } corr_state_e;

  // The trailer continues the alternation started by the last sync bit.
  localparam logic [3:0] TRL_PAT_SW1 = 4'b0101;  // syncword[0] = 1
  localparam logic [3:0] TRL_PAT_SW0 = 4'b1010;  // syncword[0] = 0

  function automatic logic [3:0] trl_pattern(input logic sw_lsb);
    return sw_lsb ? TRL_PAT_SW1 : TRL_PAT_SW0;
  endfunction

endpackage

// File: rtl/ac_popcount64.sv
// -----------------------------------------------------------------------------
// ac_popcount64
// Combinational population count of a 64-bit vector.
//   vec : input vector (sync shift register XOR expected sync word)
//   cnt : number of set bits, 0..64
// Built as eight byte counts summed afterwards, so the adder depth stays short.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module ac_popcount64 (
  input  logic [63:0] vec,
  output logic [6:0]  cnt
);

  logic [7:0][3:0] byte_cnt;

  for (genvar g = 0; g < 8; g++) begin : g_byte
    always_comb begin
      byte_cnt[g] = '0;
      for (int i = 0; i < 8; i++) byte_cnt[g] = byte_cnt[g] + 4'(vec[8*g+i]);
    end
  end

  always_comb begin
    cnt = '0;
    for (int g = 0; g < 8; g++) cnt = cnt + 7'(byte_cnt[g]);
  end

endmodule

// File: rtl/access_code_correlator.sv
// -----------------------------------------------------------------------------
// access_code_correlator
// Sliding correlation of the received bit stream against a 64-bit sync word
// inside a slot-timed search window, followed by trailer tracking that hands
// the header decoder its start tick.
//
// Ports:
//   clk_6M           6 MHz system clock
//   rstz             synchronous reset, active HIGH (despite the name)
//   p_1us            1 us bit strobe, one clock wide
//   rx_en            search enable level from slot timing
//   rxbit            demodulated bit, valid with p_1us
//   syncword         expected sync word, [63] received first
//   corr_thresh      max tolerated bit errors for a hit
//   search_win_us    search window in us, 0 = unlimited
//   sync_det_p       one-clock pulse on correlation hit
//   rx_trailer_st_p  pulse on the p_1us that starts the header decoder
//   sync_found       high in TRAILER and LOCKED
//   search_timeout_p one-clock pulse when the window expires without a hit
//   sync_errcnt      mismatch count latched at the hit
//   trailer_err      sticky: a received trailer bit mismatched
//   corr_state       current FSM state (debug)
//
// Hit timing: the p_1us carrying syncword[0] shifts on edge E0, the popcount
// is registered on E1 and the hit decision (sync_det_p, state change) is
// registered on E2. p_1us spacing is >= 6 clocks so ticks never overlap.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module access_code_correlator
  import access_code_pkg::*;
#(
  parameter int TRAILER_DLY = 2,   // 1..4 p_1us ticks after the hit
  parameter int WIN_W       = 12
) (
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              p_1us,
  input  logic              rx_en,
  input  logic              rxbit,
  input  logic [SW_LEN-1:0] syncword,
  input  logic [2:0]        corr_thresh,
  input  logic [WIN_W-1:0]  search_win_us,
  output logic              sync_det_p,
  output logic              rx_trailer_st_p,
  output logic              sync_found,
  output logic              search_timeout_p,
  output logic [6:0]        sync_errcnt,
  output logic              trailer_err,
  output logic [2:0]        corr_state
);

  localparam logic [1:0] TRL_LAST = 2'(TRAILER_DLY - 1);
  localparam logic [6:0] BITS_FULL = 7'(SW_LEN);

  corr_state_e       state;
  logic [SW_LEN-1:0] sr;
  logic [6:0]        bits_in;
  logic [6:0]        errcnt_r;
  logic [6:0]        popcnt;
  logic [WIN_W-1:0]  win_cnt;
  logic [1:0]        trl_cnt;
  // [0]: shift done last edge, popcount input is fresh
  // [1]: errcnt_r holds the result for that tick, decide this edge
  logic [1:0]        vld_pipe;

  logic              hit;
  logic              win_done;
  logic              trl_tick;
  logic [3:0]        trl_pat;
  logic              trl_exp_bit;

  ac_popcount64 u_popcount (
    .vec (sr ^ syncword),
    .cnt (popcnt)
  );

  // bits_in guard keeps a hit impossible before the register is full.
  assign hit      = vld_pipe[1] && (bits_in == BITS_FULL) &&
                    (errcnt_r <= {4'd0, corr_thresh});
  assign win_done = vld_pipe[1] && (search_win_us != '0) &&
                    (win_cnt == search_win_us);

  assign trl_tick    = p_1us && rx_en && (state == ST_TRAILER);
  assign trl_pat     = trl_pattern(syncword[0]);
  assign trl_exp_bit = trl_pat[2'd3 - trl_cnt];

  // Combinational so it lines up with the p_1us the header decoder starts on.
  assign rx_trailer_st_p = trl_tick && (trl_cnt == TRL_LAST) && !rstz;

  assign sync_found = (state == ST_TRAILER) || (state == ST_LOCKED);
  assign corr_state = state;

  always_ff @(posedge clk_6M) begin
    if (rstz) begin
      state            <= ST_IDLE;
      sr               <= '0;
      bits_in          <= '0;
      errcnt_r         <= '0;
      win_cnt          <= '0;
      trl_cnt          <= '0;
      vld_pipe         <= '0;
      sync_det_p       <= 1'b0;
      search_timeout_p <= 1'b0;
      sync_errcnt      <= '0;
      trailer_err      <= 1'b0;
    end else begin
      sync_det_p       <= 1'b0;
      search_timeout_p <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (rx_en) begin
            state       <= ST_SEARCH;
            sr          <= '0;
            bits_in     <= '0;
            win_cnt     <= '0;
            trl_cnt     <= '0;
            vld_pipe    <= '0;
            sync_errcnt <= '0;
            trailer_err <= 1'b0;
          end
        end

        ST_SEARCH: begin
          if (!rx_en) begin
            // Abort beats a hit or timeout decided on the same edge.
            state    <= ST_IDLE;
            vld_pipe <= '0;
          end else begin
            vld_pipe <= {vld_pipe[0], p_1us};
            if (p_1us) begin
              sr <= {sr[SW_LEN-2:0], rxbit};
              if (bits_in != BITS_FULL) bits_in <= bits_in + 7'd1;
              if (win_cnt != '1)        win_cnt <= win_cnt + 1'b1;
            end
            if (vld_pipe[0]) errcnt_r <= popcnt;
            // Hit takes priority over window expiry on the same tick.
            if (hit) begin
              sync_det_p  <= 1'b1;
              sync_errcnt <= errcnt_r;
              state       <= ST_TRAILER;
            end else if (win_done) begin
              search_timeout_p <= 1'b1;
              state            <= ST_EXPIRED;
            end
          end
        end

        ST_TRAILER: begin
          if (!rx_en) begin
            state <= ST_IDLE;
          end else if (p_1us) begin
            trl_cnt <= trl_cnt + 2'd1;
            if (rxbit != trl_exp_bit) trailer_err <= 1'b1;
            if (trl_cnt == TRL_LAST)  state <= ST_LOCKED;
          end
        end

        // Terminal until slot timing drops rx_en; no re-search in between.
        ST_LOCKED, ST_EXPIRED: begin
          if (!rx_en) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_access_code_correlator.sv
`timescale 1ns/1ps
module tb_access_code_correlator;

  localparam int K_DET = 0;
  localparam int K_TRL = 1;
  localparam int K_TMO = 2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SEARCH  = 3'd1;
  localparam logic [2:0] S_TRAILER = 3'd2;
  localparam logic [2:0] S_LOCKED  = 3'd3;
  localparam logic [2:0] S_EXPIRED = 3'd4;

  localparam logic [63:0] SW  = 64'hA5C3_0F1E_9B7D_2468;  // lsb 0 -> trailer 1,0,1,0
  localparam logic [63:0] SW2 = 64'hA5C3_0F1E_9B7D_2469;  // lsb 1 -> trailer 0,1,0,1
  localparam logic [63:0] SW3 = 64'h25C3_0F1E_9B7D_2468;  // msb 0, fits a cleared register after 63 shifts
  localparam logic [63:0] FL3 = 64'h8000_0000_4000_0001;  // bits 63,30,0
  localparam logic [63:0] FL4 = 64'h8000_0100_0010_0020;  // bits 63,40,20,5
  localparam logic [63:0] FL2 = 64'h0004_0000_0000_0400;  // bits 50,10

  logic        clk_6M = 1'b0;
  logic        rstz, p_1us, rx_en, rxbit;
  logic [63:0] syncword;
  logic [2:0]  corr_thresh;
  logic [11:0] search_win_us;
  logic        sync_det_p, rx_trailer_st_p, sync_found, search_timeout_p;
  logic [6:0]  sync_errcnt;
  logic        trailer_err;
  logic [2:0]  corr_state;

  typedef struct {
    int kind;
    int cyc;
    int ec;
  } ev_t;

  ev_t q[$];
  int  cyc   = 0;
  int  n_chk = 0;
  int  n_bad = 0;

  access_code_correlator #(.TRAILER_DLY(2), .WIN_W(12)) dut (
    .clk_6M           (clk_6M),
    .rstz             (rstz),
    .p_1us            (p_1us),
    .rx_en            (rx_en),
    .rxbit            (rxbit),
    .syncword         (syncword),
    .corr_thresh      (corr_thresh),
    .search_win_us    (search_win_us),
    .sync_det_p       (sync_det_p),
    .rx_trailer_st_p  (rx_trailer_st_p),
    .sync_found       (sync_found),
    .search_timeout_p (search_timeout_p),
    .sync_errcnt      (sync_errcnt),
    .trailer_err      (trailer_err),
    .corr_state       (corr_state)
  );

  always #5 clk_6M = ~clk_6M;
  always @(posedge clk_6M) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Pulse monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk_6M) begin : mon
    ev_t e;
    int  k;
    if (sync_det_p || rx_trailer_st_p || search_timeout_p) begin
      k = sync_det_p ? K_DET : (rx_trailer_st_p ? K_TRL : K_TMO);
      if (q.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, want none", k, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", k, e.kind);
        chk("pulse_cycle", cyc, e.cyc);
        if (k == K_DET) chk("sync_errcnt_at_hit", int'(sync_errcnt), e.ec);
      end
    end
  end

  // One bit strobe; expected pulse (if any) is queued as the tick is issued.
  // Hit/timeout appear 3 edges after the drive cycle, trailer start same cycle.
  task automatic send_bit(input logic b, input int kind, input int ec);
    ev_t e;
    @(posedge clk_6M); #1;
    p_1us = 1'b1;
    rxbit = b;
    if (kind >= 0) begin
      e.kind = kind;
      e.cyc  = (kind == K_TRL) ? cyc : cyc + 3;
      e.ec   = ec;
      q.push_back(e);
    end
    @(posedge clk_6M); #1;
    p_1us = 1'b0;
    rxbit = 1'b0;
    repeat (5) @(posedge clk_6M);
  endtask

  task automatic send_word(input logic [63:0] w, input int n, input int kind, input int ec);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], (i == 0) ? kind : -1, ec);
  endtask

  task automatic start(input logic [63:0] sw, input logic [2:0] thr, input logic [11:0] win);
    @(posedge clk_6M); #1;
    syncword      = sw;
    corr_thresh   = thr;
    search_win_us = win;
    rx_en         = 1'b1;
    @(posedge clk_6M);
    @(negedge clk_6M);
    chk("state_search", int'(corr_state), int'(S_SEARCH));
  endtask

  task automatic drop_en();
    @(posedge clk_6M); #1;
    rx_en = 1'b0;
    @(posedge clk_6M);
    @(negedge clk_6M);
    chk("state_idle_after_drop", int'(corr_state), int'(S_IDLE));
    chk("sync_found_idle", int'(sync_found), 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    logic [63:0] pre;
    pre           = 64'hA;  // preamble 1,0,1,0
    rstz          = 1'b1;
    p_1us         = 1'b0;
    rx_en         = 1'b0;
    rxbit         = 1'b0;
    syncword      = SW;
    corr_thresh   = 3'd0;
    search_win_us = 12'd0;

    // Reset state
    repeat (3) @(posedge clk_6M);
    @(negedge clk_6M);
    chk("rst_state", int'(corr_state), int'(S_IDLE));
    chk("rst_sync_found", int'(sync_found), 0);
    chk("rst_sync_det", int'(sync_det_p), 0);
    chk("rst_timeout", int'(search_timeout_p), 0);
    chk("rst_trl_st", int'(rx_trailer_st_p), 0);
    chk("rst_errcnt", int'(sync_errcnt), 0);
    chk("rst_trailer_err", int'(trailer_err), 0);
    @(posedge clk_6M); #1;
    rstz = 1'b0;

    // Exact match, correct trailer for lsb 0 (1 then 0)
    start(SW, 3'd0, 12'd0);
    send_word(pre, 4, -1, 0);
    send_word(SW, 64, K_DET, 0);
    @(negedge clk_6M);
    chk("t1_state_trailer", int'(corr_state), int'(S_TRAILER));
    chk("t1_sync_found", int'(sync_found), 1);
    send_bit(1'b1, -1, 0);
    send_bit(1'b0, K_TRL, 0);
    @(negedge clk_6M);
    chk("t1_state_locked", int'(corr_state), int'(S_LOCKED));
    chk("t1_sync_found_locked", int'(sync_found), 1);
    chk("t1_trailer_err", int'(trailer_err), 0);
    chk("t1_errcnt", int'(sync_errcnt), 0);
    drop_en();

    // Three flipped bits within threshold 3
    start(SW, 3'd3, 12'd0);
    send_word(pre, 4, -1, 0);
    send_word(SW ^ FL3, 64, K_DET, 3);
    send_bit(1'b1, -1, 0);
    send_bit(1'b0, K_TRL, 0);
    @(negedge clk_6M);
    chk("t2_state_locked", int'(corr_state), int'(S_LOCKED));
    chk("t2_trailer_err", int'(trailer_err), 0);
    drop_en();
    chk("t2_errcnt_hold_idle", int'(sync_errcnt), 3);

    // Four flipped bits: no hit, timeout at tick 80 (4 + 64 + 12)
    start(SW, 3'd3, 12'd80);
    chk("t3_errcnt_cleared", int'(sync_errcnt), 0);
    send_word(pre, 4, -1, 0);
    send_word(SW ^ FL4, 64, -1, 0);
    for (int i = 1; i <= 12; i++) send_bit(i % 3 == 0, (i == 12) ? K_TMO : -1, 0);
    @(negedge clk_6M);
    chk("t3_state_expired", int'(corr_state), int'(S_EXPIRED));
    chk("t3_sync_found", int'(sync_found), 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, -1, 0);
    drop_en();

    // Early-hit guard: register equals the word after 63 shifts, no hit yet
    start(SW3, 3'd0, 12'd0);
    send_word(SW3, 63, -1, 0);
    send_word(SW3, 64, K_DET, 0);
    @(negedge clk_6M);
    chk("t4_state_trailer", int'(corr_state), int'(S_TRAILER));
    // Abort in TRAILER: no trailer start afterwards
    @(posedge clk_6M); #1;
    rx_en = 1'b0;
    send_bit(1'b1, -1, 0);
    send_bit(1'b0, -1, 0);
    @(negedge clk_6M);
    chk("t4_state_idle", int'(corr_state), int'(S_IDLE));
    chk("t4_sync_found", int'(sync_found), 0);

    // Window of 20 with noise
    start(SW, 3'd0, 12'd20);
    for (int i = 1; i <= 20; i++) send_bit(i % 3 == 1, (i == 20) ? K_TMO : -1, 0);
    @(negedge clk_6M);
    chk("t5_state_expired", int'(corr_state), int'(S_EXPIRED));
    for (int i = 0; i < 3; i++) send_bit(1'b0, -1, 0);
    @(negedge clk_6M);
    chk("t5_state_still_expired", int'(corr_state), int'(S_EXPIRED));
    drop_en();

    // Trailer error: lsb 1 expects 0,1 but 1,1 arrives
    start(SW2, 3'd0, 12'd0);
    send_word(SW2, 64, K_DET, 0);
    send_bit(1'b1, -1, 0);
    send_bit(1'b1, K_TRL, 0);
    @(negedge clk_6M);
    chk("t6_state_locked", int'(corr_state), int'(S_LOCKED));
    chk("t6_trailer_err", int'(trailer_err), 1);
    drop_en();
    chk("t6_trailer_err_hold", int'(trailer_err), 1);

    // Reset in TRAILER
    start(SW, 3'd3, 12'd0);
    chk("t7_trailer_err_cleared", int'(trailer_err), 0);
    send_word(SW ^ FL2, 64, K_DET, 2);
    send_bit(1'b0, -1, 0);  // expected first trailer bit is 1
    @(negedge clk_6M);
    chk("t7_state_trailer", int'(corr_state), int'(S_TRAILER));
    chk("t7_errcnt", int'(sync_errcnt), 2);
    chk("t7_trailer_err", int'(trailer_err), 1);
    @(posedge clk_6M); #1;
    rstz = 1'b1;
    @(posedge clk_6M);
    @(negedge clk_6M);
    chk("t7_rst_state", int'(corr_state), int'(S_IDLE));
    chk("t7_rst_sync_found", int'(sync_found), 0);
    chk("t7_rst_errcnt", int'(sync_errcnt), 0);
    chk("t7_rst_trailer_err", int'(trailer_err), 0);
    @(posedge clk_6M); #1;
    rstz = 1'b0;
    @(posedge clk_6M);
    @(negedge clk_6M);
    chk("t7_search_after_rst", int'(corr_state), int'(S_SEARCH));
    send_word(SW, 64, K_DET, 0);
    drop_en();

    repeat (10) @(posedge clk_6M);
    chk("pending_expectations", q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
